// File: rtl/dpwm_gate_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : dpwm_gate_driver_if
//  Brief    : Duty-command / gate-drive bundle between compensator and DPWM.
//  Revision : 1.0  initial release
// ============================================================================
interface dpwm_gate_driver_if #(
  parameter int DUTY_W = 9
);
  logic              enable;
  logic [DUTY_W-1:0] duty_in;
  logic              hs_gate;
  logic              ls_gate;
  logic              period_start;
  logic              sample_trig;
  logic [DUTY_W-1:0] duty_active;

  modport master (
    output enable,
    output duty_in,
    input  hs_gate,
    input  ls_gate,
    input  period_start,
    input  sample_trig,
    input  duty_active
  );

  modport slave (
    input  enable,
    input  duty_in,
    output hs_gate,
    output ls_gate,
    output period_start,
    output sample_trig,
    output duty_active
  );
endinterface
`default_nettype wire

// File: rtl/dpwm_gate_driver.sv
`default_nettype none
// ============================================================================
//  Module   : dpwm_gate_driver
//  Brief    : Counter DPWM with double-buffered duty, complementary gate FSM,
//             period strobe and ADC trigger. Define DPWM_DEADTIME_EN for
//             dead-time insertion between gate transitions.
//  Revision : 1.0  initial release
// ============================================================================
module dpwm_gate_driver #(
  parameter int DUTY_W    = 9,
  parameter int DUTY_MAX  = 486,
  parameter int SAMPLE_PT = 256,
  parameter int DEADTIME  = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dpwm_gate_driver_if.slave bus
);

  localparam logic [DUTY_W-1:0] c_cnt_max   = '1;
  localparam logic [DUTY_W-1:0] c_duty_max  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] c_sample_pt = DUTY_W'(SAMPLE_PT);

  localparam logic [2:0] c_st_off   = 3'd0;
  localparam logic [2:0] c_st_hs_on = 3'd1;
  localparam logic [2:0] c_st_dt_hl = 3'd2;
  localparam logic [2:0] c_st_ls_on = 3'd3;
  localparam logic [2:0] c_st_dt_lh = 3'd4;

  if (DEADTIME < 1 || DEADTIME > 7) begin : g_deadtime_range
    $error("dpwm_gate_driver: DEADTIME must lie in 1..7");
  end
  if (DUTY_MAX >= (2 ** DUTY_W)) begin : g_duty_max_range
    $error("dpwm_gate_driver: DUTY_MAX must be below 2**DUTY_W");
  end

  logic [DUTY_W-1:0] r_cnt;
  logic [DUTY_W-1:0] r_duty_q;
  logic              r_period_start;
  logic              r_sample_trig;
  logic [2:0]        r_state;
  logic              r_hs;
  logic              r_ls;

  logic              w_wrap;
  logic [DUTY_W-1:0] w_duty_clamped;
  logic              w_pwm_raw;
  logic [2:0]        w_state_next;
  logic              w_hs_next;
  logic              w_ls_next;

`ifdef DPWM_DEADTIME_EN
  localparam logic [2:0] c_dt_load = 3'(DEADTIME - 1);
  logic [2:0] r_dt_cnt;
  logic       w_dt_load;
`endif

  assign w_wrap         = bus.enable && (r_cnt == c_cnt_max);
  assign w_duty_clamped = (bus.duty_in > c_duty_max) ? c_duty_max : bus.duty_in;
  assign w_pwm_raw      = bus.enable && (r_cnt < r_duty_q);

  // Counter parks at max while disabled so the first enabled clk wraps and
  // latches a fresh duty for a complete first period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt          <= c_cnt_max;
      r_duty_q       <= '0;
      r_period_start <= 1'b0;
      r_sample_trig  <= 1'b0;
    end else begin
      if (bus.enable) begin
        r_cnt <= r_cnt + DUTY_W'(1);
      end else begin
        r_cnt <= c_cnt_max;
      end
      if (w_wrap) begin
        r_duty_q <= w_duty_clamped;
      end
      r_period_start <= bus.enable && (r_cnt == '0);
      r_sample_trig  <= bus.enable && (r_cnt == c_sample_pt);
    end
  end

  // Gate FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_off;
      r_hs    <= 1'b0;
      r_ls    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hs    <= w_hs_next;
      r_ls    <= w_ls_next;
    end
  end

`ifdef DPWM_DEADTIME_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dt_cnt <= 3'd0;
    end else if (w_dt_load) begin
      r_dt_cnt <= c_dt_load;
    end else if (r_dt_cnt != 3'd0) begin
      r_dt_cnt <= r_dt_cnt - 3'd1;
    end
  end
`endif

  // Gate FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
`ifdef DPWM_DEADTIME_EN
    w_dt_load    = 1'b0;
`endif
    if (!bus.enable) begin
      w_state_next = c_st_off;
    end else begin
      case (r_state)
        c_st_off: begin
          w_state_next = w_pwm_raw ? c_st_hs_on : c_st_ls_on;
        end
        c_st_hs_on: begin
          if (!w_pwm_raw) begin
`ifdef DPWM_DEADTIME_EN
            w_state_next = c_st_dt_hl;
            w_dt_load    = 1'b1;
`else
            w_state_next = c_st_ls_on;
`endif
          end
        end
        c_st_ls_on: begin
          if (w_pwm_raw) begin
`ifdef DPWM_DEADTIME_EN
            w_state_next = c_st_dt_lh;
            w_dt_load    = 1'b1;
`else
            w_state_next = c_st_hs_on;
`endif
          end
        end
`ifdef DPWM_DEADTIME_EN
        // A pwm_raw reversal inside the dead band swallows the short pulse.
        c_st_dt_hl: begin
          if (w_pwm_raw) begin
            w_state_next = c_st_hs_on;
          end else if (r_dt_cnt == 3'd0) begin
            w_state_next = c_st_ls_on;
          end
        end
        c_st_dt_lh: begin
          if (!w_pwm_raw) begin
            w_state_next = c_st_ls_on;
          end else if (r_dt_cnt == 3'd0) begin
            w_state_next = c_st_hs_on;
          end
        end
`else
        c_st_dt_hl, c_st_dt_lh: begin
          w_state_next = c_st_off;
        end
`endif
        default: begin
          w_state_next = c_st_off;
        end
      endcase
    end
  end

  // Gate FSM: outputs decoded from the next state, then registered
  always_comb begin
    w_hs_next = 1'b0;
    w_ls_next = 1'b0;
    case (w_state_next)
      c_st_hs_on: w_hs_next = 1'b1;
      c_st_ls_on: w_ls_next = 1'b1;
      default: begin
        w_hs_next = 1'b0;
        w_ls_next = 1'b0;
      end
    endcase
  end

  assign bus.hs_gate      = r_hs;
  assign bus.ls_gate      = r_ls;
  assign bus.period_start = r_period_start;
  assign bus.sample_trig  = r_sample_trig;
  assign bus.duty_active  = r_duty_q;

endmodule
`default_nettype wire

// File: doc/dpwm_gate_driver.md
Name: dpwm_gate_driver

Overview:
- Counter-based digital PWM that consumes the 9-bit duty word from the PID compensator stage.
- Produces complementary high-side and low-side gate drives for the synchronous buck power stage.
- Issues a once-per-period strobe and an ADC sample trigger, so the error ADC and compensator update once per switching period.
- Duty is double-buffered and changes only at period boundaries.

Parameters:
- DUTY_W, 9, width of duty word and period counter; period = 2^DUTY_W clk cycles.
- DUTY_MAX, 486, upper clamp on the latched duty, in counts.
- SAMPLE_PT, 256, counter value at which sample_trig pulses.
- DEADTIME, 2, dead-time in clk cycles. Used only with DPWM_DEADTIME_EN; legal range 1..7.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high.
- enable, input, 1, modulator run enable; synchronous.
- duty_in, input, DUTY_W, unsigned duty command from the compensator.
- hs_gate, output, 1, high-side switch drive (1 = on).
- ls_gate, output, 1, low-side switch drive (1 = on).
- period_start, output, 1, one-cycle pulse on the first cycle of each period.
- sample_trig, output, 1, one-cycle pulse at SAMPLE_PT; starts the error ADC.
- duty_active, output, DUTY_W, duty value currently being modulated (the shadow register).

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- Reset values:
  - cnt = 2^DUTY_W-1, duty_q = 0.
  - hs_gate = 0, ls_gate = 0, period_start = 0, sample_trig = 0.
  - duty_active = 0.
  - FSM in OFF.
- Counter:
  - cnt is unsigned DUTY_W bits.
  - When enable = 1: increments each clk and wraps 2^DUTY_W-1 -> 0.
  - When enable = 0: cnt is forced to 2^DUTY_W-1 on the next clk.
- Duty load:
  - Occurs on the clk where cnt wraps to 0 (cnt == max and enable == 1).
  - Loads duty_q <= (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in.
  - Writes to duty_in at any other time have no effect until the next wrap.
  - duty_active = duty_q.
- Raw PWM: pwm_raw = enable & (cnt < duty_q).
  - duty_q = 0 gives 0% on-time.
  - 100% on-time is never produced, because DUTY_MAX < 2^DUTY_W.
- Gate FSM (registered outputs). States OFF, HS_ON, DT_HL, LS_ON, DT_LH.
  - OFF: both gates 0. On enable = 1, go to HS_ON if pwm_raw, else LS_ON.
  - HS_ON: hs = 1, ls = 0. On pwm_raw = 0, go to DT_HL, or straight to LS_ON when dead-time is compiled out.
  - DT_HL: both gates 0 for DEADTIME cycles, then LS_ON.
  - LS_ON: hs = 0, ls = 1. On pwm_raw = 1, go to DT_LH, or straight to HS_ON when dead-time is compiled out.
  - DT_LH: both gates 0 for DEADTIME cycles, then HS_ON.
  - enable = 0 in any state goes to OFF on the next clk; both gates 0 that cycle.
  - Both gates are never 1 in the same cycle.
- Latency: a gate output follows pwm_raw by 1 clk, plus DEADTIME on each turn-on edge when dead-time is enabled.
- Re-enable: first enabled clk loads the duty and sets cnt = 0, so the first period is complete and uses fresh duty.
- Strobes:
  - period_start is registered = 1 in the cycle after cnt becomes 0, aligned with the first gate cycle.
  - sample_trig is likewise registered at cnt == SAMPLE_PT.
  - Both strobes are 0 while enable = 0.
- Reset mid-period: all outputs go to reset values immediately, asynchronously. Operation restarts as re-enable after reset is released.

Optional Feature:
- DPWM_DEADTIME_EN defined:
  - DT_HL/DT_LH are entered on every edge of pwm_raw; a 3-bit down-counter holds both gates low for DEADTIME cycles.
  - If pwm_raw toggles back during dead-time, the FSM returns to the gate that was on before the dead-time (HS_ON if leaving DT_HL, LS_ON if leaving DT_LH) and the pulse is swallowed.
  - A pulse shorter than DEADTIME therefore never asserts the opposite gate.
- Undefined:
  - DT states are unreachable and the dead-time counter is removed.
  - While enabled, ls_gate = ~hs_gate, with zero dead-time.

Test Plan:
- Reset, enable = 1, duty_in = 100 -> per 512-cycle period: hs_gate high 100 cycles, ls_gate high 412 cycles; period_start every 512 cycles; sample_trig 256 cycles after period_start.
- duty_in changed 100 -> 300 at cnt = 50 -> current period still 100 high; next period 300 high; duty_active changes at the wrap.
- duty_in = 0 -> hs_gate never high, ls_gate high all 512 cycles; duty_in = 511 -> clamped, duty_active = 486, hs high 486 cycles.
- enable dropped at cnt = 40 -> next clk both gates 0, no strobes. Re-enable -> period_start on the 2nd enabled clk, full period at the latched duty.
- Reset asserted mid-HS_ON -> hs_gate and ls_gate 0 asynchronously, duty_active = 0.
- DPWM_DEADTIME_EN, DEADTIME = 2, duty = 100 -> both gates low 2 cycles at each transition: hs high 98 cycles, ls high 410 cycles. Never hs & ls simultaneously.
